// File: rtl/attendance_pkg.sv
// Shared encodings and constants for the attendance roll-call sequencer
// and the register bank it feeds.
package attendance_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        UPD  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int CNT_W = 7;
    localparam int MAX_SESSIONS_DEF = 100;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] max
    );
        return (cnt >= max) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/attendance_session_ctrl_roll_timer.sv
// Per-student response timer: synchronous clear to zero, count-enable,
// and an expire flag on the last allowed WAIT cycle.
module roll_timer #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/attendance_session_ctrl.sv
// Roll-call sequencer: polls each student, waits for a mark or timeout,
// and pushes exactly one valid/ready update per student into the bank.
import attendance_pkg::*;

module attendance_session_ctrl #(
    parameter int NUM_STUDENTS = 8,
    parameter int ID_W         = 3,
    parameter int TIMEOUT      = 15,
    parameter int TO_W         = 4,
    parameter int MAX_SESSIONS = MAX_SESSIONS_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             mark_valid,
    input  logic             mark_present,
    output logic             roll_req,
    output logic [ID_W-1:0]  roll_id,
    output logic             upd_valid,
    output logic [ID_W-1:0]  upd_id,
    output logic             upd_present,
    input  logic             upd_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] session_count,
    output logic [ID_W:0]    absent_count,
    output logic             sessions_full
);

    localparam logic [ID_W-1:0]  LAST = ID_W'(NUM_STUDENTS - 1);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(MAX_SESSIONS);

    state_t state;
    logic   abort_pend;
    logic   expire;
    logic   t_clear;
    logic   t_en;

    // Timer only runs while waiting; every other state parks it at zero.
    assign t_clear = (state != WAIT);
    assign t_en    = (state == WAIT) && !abort && !mark_valid && !expire;

    roll_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk    (clk),
        .rst    (clr),
        .clear  (t_clear),
        .enable (t_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            roll_id       <= '0;
            upd_present   <= 1'b0;
            abort_pend    <= 1'b0;
            session_count <= '0;
            absent_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !sessions_full) begin
                        state        <= WAIT;
                        roll_id      <= '0;
                        absent_count <= '0;
                        abort_pend   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (mark_valid) begin
                        upd_present <= mark_present;
                        state       <= UPD;
                    end else if (expire) begin
                        upd_present <= 1'b0;
                        state       <= UPD;
                    end
                end
                UPD: begin
                    if (upd_ready) begin
                        absent_count <= absent_count
                                      + {{ID_W{1'b0}}, ~upd_present};
                        if (abort_pend || abort) begin
                            state      <= IDLE;
                            abort_pend <= 1'b0;
                        end else if (roll_id == LAST) begin
                            state <= FIN;
                        end else begin
                            roll_id <= roll_id + 1'b1;
                            state   <= WAIT;
                        end
                    end else if (abort) begin
                        // Defer the abort so the pending update still lands.
                        abort_pend <= 1'b1;
                    end
                end
                FIN: begin
                    session_count <= sat_inc(session_count, SMAX);
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign roll_req      = (state == WAIT);
    assign upd_valid     = (state == UPD);
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);
    assign upd_id        = roll_id;
    assign sessions_full = (session_count == SMAX);

endmodule

// File: tb/tb_attendance_session_ctrl.sv
// Bench: builds a per-cycle timeline of each session from the roll-call
// rules, drives it into the sequencer and checks every cycle.
module tb_attendance_session_ctrl;

    localparam int N    = 8;
    localparam int T    = 15;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       abort;
    logic       mark_valid;
    logic       mark_present;
    logic       upd_ready;
    logic       roll_req;
    logic [2:0] roll_id;
    logic       upd_valid;
    logic [2:0] upd_id;
    logic       upd_present;
    logic       busy;
    logic       done;
    logic [6:0] session_count;
    logic [3:0] absent_count;
    logic       sessions_full;

    attendance_session_ctrl #(
        .NUM_STUDENTS (N),
        .ID_W         (3),
        .TIMEOUT      (T),
        .TO_W         (4),
        .MAX_SESSIONS (MAXS)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .start         (start),
        .abort         (abort),
        .mark_valid    (mark_valid),
        .mark_present  (mark_present),
        .roll_req      (roll_req),
        .roll_id       (roll_id),
        .upd_valid     (upd_valid),
        .upd_id        (upd_id),
        .upd_present   (upd_present),
        .upd_ready     (upd_ready),
        .busy          (busy),
        .done          (done),
        .session_count (session_count),
        .absent_count  (absent_count),
        .sessions_full (sessions_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit st, ab, mv, mp, rdy;
        bit busy, rreq, uv, up, done;
        int rid, absn, sc;
    } step_t;

    step_t tl[$];
    int    checks = 0;
    int    errors = 0;
    int    m_sess = 0;
    int    m_abs  = 0;
    int    dly[N];
    bit    pres[N];
    int    stall[N];
    int    ab_mode, ab_stu, ab_off;
    int    exp_done_idx;
    int    last_done;
    int    idx;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic push_idle(input bit st);
        step_t s;
        s = '{default:0};
        s.st = st;
        s.rid = N - 1;
        s.absn = m_abs;
        s.sc = m_sess;
        tl.push_back(s);
    endtask

    task automatic rand_plan();
        for (int i = 0; i < N; i++) begin
            dly[i]   = $urandom_range(0, T + 2);
            pres[i]  = 1'($urandom % 2);
            stall[i] = ($urandom % 4 == 0) ? $urandom_range(1, 4) : 0;
        end
        ab_mode = 0;
    endtask

    // Expected timeline: WAIT lasts mark-offset+1 cycles (or T on timeout),
    // UPD lasts stall+1 cycles, then one FIN cycle.
    task automatic build();
        step_t s;
        int wl;
        bit pv;
        tl.delete();
        exp_done_idx = -1;
        push_idle(1'b1);
        if (m_sess == MAXS) begin
            push_idle(1'b0);
            return;
        end
        m_abs = 0;
        for (int i = 0; i < N; i++) begin
            wl = (dly[i] < T) ? dly[i] + 1 : T;
            pv = (dly[i] < T) ? pres[i] : 1'b0;
            for (int k = 0; k < wl; k++) begin
                s = '{default:0};
                s.busy = 1; s.rreq = 1; s.rid = i;
                s.absn = m_abs; s.sc = m_sess;
                s.st = 1'($urandom % 2);
                s.rdy = 1'($urandom % 2);
                s.mv = (dly[i] < T) && (k == dly[i]);
                s.mp = s.mv ? pres[i] : 1'($urandom % 2);
                s.ab = (ab_mode == 1) && (ab_stu == i) && (ab_off == k);
                tl.push_back(s);
                if (s.ab) begin
                    push_idle(1'b0);
                    return;
                end
            end
            for (int j = 0; j <= stall[i]; j++) begin
                s = '{default:0};
                s.busy = 1; s.uv = 1; s.rid = i; s.up = pv;
                s.absn = m_abs; s.sc = m_sess;
                s.rdy = (j == stall[i]);
                s.st = 1'($urandom % 2);
                s.mv = 1'($urandom % 2);
                s.mp = 1'($urandom % 2);
                s.ab = (ab_mode == 2) && (ab_stu == i) && (j == 0);
                tl.push_back(s);
            end
            m_abs += pv ? 0 : 1;
            if (ab_mode == 2 && ab_stu == i) begin
                push_idle(1'b0);
                return;
            end
        end
        s = '{default:0};
        s.busy = 1; s.done = 1; s.rid = N - 1;
        s.absn = m_abs; s.sc = m_sess;
        exp_done_idx = tl.size();
        tl.push_back(s);
        m_sess = (m_sess + 1 > MAXS) ? MAXS : m_sess + 1;
        push_idle(1'b0);
    endtask

    task automatic play(input int upto);
        step_t s;
        last_done = -1;
        for (int j = 0; j < upto; j++) begin
            @(negedge clk);
            s = tl[j];
            chk("busy", busy, s.busy);
            chk("roll_req", roll_req, s.rreq);
            chk("upd_valid", upd_valid, s.uv);
            chk("done", done, s.done);
            chk("absent_count", absent_count, s.absn);
            chk("session_count", session_count, s.sc);
            chk("sessions_full", sessions_full, s.sc == MAXS);
            if (s.rreq || s.uv) chk("roll_id", roll_id, s.rid);
            if (s.uv) begin
                chk("upd_id", upd_id, s.rid);
                chk("upd_present", upd_present, s.up);
            end
            if (done === 1'b1 && last_done < 0) last_done = j;
            start        = s.st;
            abort        = s.ab;
            mark_valid   = s.mv;
            mark_present = s.mp;
            upd_ready    = s.rdy;
        end
        if (upto == tl.size()) chk("done_cycle", last_done, exp_done_idx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        start = 0; abort = 0; mark_valid = 0;
        mark_present = 0; upd_ready = 0;
        @(negedge clk);
        clr = 1'b0;
        m_sess = 0;
        m_abs = 0;
    endtask

    initial begin
        clr = 1'b1;
        start = 0; abort = 0; mark_valid = 0;
        mark_present = 0; upd_ready = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_roll_req", roll_req, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_roll_id", roll_id, 0);
        chk("rst_session_count", session_count, 0);
        chk("rst_absent_count", absent_count, 0);
        chk("rst_sessions_full", sessions_full, 0);
        @(negedge clk);
        clr = 1'b0;

        // Full attendance, no stalls
        for (int i = 0; i < N; i++) begin
            dly[i] = 0; pres[i] = 1; stall[i] = 0;
        end
        ab_mode = 0;
        build(); play(tl.size());
        chk("full_done_at", last_done, 2 * N + 1);
        chk("full_absent", absent_count, 0);
        chk("full_sessions", session_count, 1);

        // Every student times out
        for (int i = 0; i < N; i++) dly[i] = T;
        build(); play(tl.size());
        chk("to_done_at", last_done, N * (T + 1) + 1);
        chk("to_absent", absent_count, N);

        // Bank backpressure on student 3
        for (int i = 0; i < N; i++) begin
            dly[i] = 0; pres[i] = 1'($urandom % 2); stall[i] = 0;
        end
        stall[3] = 5;
        build(); play(tl.size());
        chk("bp_sessions", session_count, MAXS);
        chk("bp_full", sessions_full, 1);

        // Saturated: start must be ignored
        build(); play(tl.size());
        chk("sat_busy", busy, 0);
        chk("sat_sessions", session_count, MAXS);

        // Mark arriving on the expiry cycle wins
        do_reset();
        for (int i = 0; i < N; i++) begin
            dly[i] = T - 1; pres[i] = 1; stall[i] = 0;
        end
        build(); play(tl.size());
        chk("tie_absent", absent_count, 0);

        // Abort in WAIT of student 2, on its mark cycle
        rand_plan();
        dly[2] = 3;
        ab_mode = 1; ab_stu = 2; ab_off = 3;
        build(); play(tl.size());
        chk("abw_sessions", session_count, 1);
        chk("abw_no_done", last_done, -1);

        // Abort in UPD under backpressure
        rand_plan();
        stall[4] = 3;
        ab_mode = 2; ab_stu = 4;
        build(); play(tl.size());
        chk("abu_sessions", session_count, 1);

        // Randomized sessions, some aborted
        for (int r = 0; r < 14; r++) begin
            if (m_sess == MAXS && ($urandom % 2) == 1) do_reset();
            rand_plan();
            if ($urandom % 3 == 0) begin
                ab_mode = $urandom_range(1, 2);
                ab_stu = $urandom_range(0, N - 1);
                ab_off = $urandom_range(0,
                    (dly[ab_stu] < T) ? dly[ab_stu] : T - 1);
            end
            build(); play(tl.size());
        end

        // Reset asserted between edges in the middle of an update
        do_reset();
        rand_plan();
        build(); play(tl.size());
        for (int i = 0; i < N; i++) begin
            dly[i] = 0; stall[i] = 0;
        end
        stall[2] = 10;
        build();
        idx = 0;
        while (!(tl[idx].uv && tl[idx].rid == 2)) idx++;
        play(idx + 3);
        #2 clr = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_roll_req", roll_req, 0);
        chk("mid_upd_valid", upd_valid, 0);
        chk("mid_upd_id", upd_id, 0);
        chk("mid_upd_present", upd_present, 0);
        chk("mid_roll_id", roll_id, 0);
        chk("mid_session_count", session_count, 0);
        chk("mid_absent_count", absent_count, 0);
        chk("mid_sessions_full", sessions_full, 0);
        @(negedge clk);
        clr = 1'b0;
        start = 0; abort = 0; mark_valid = 0; upd_ready = 0;
        m_sess = 0;
        m_abs = 0;
        rand_plan();
        build(); play(tl.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
